ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter REPEAT_DELAY, default 6250000, cycles from make to first auto-repeat pulse (250 ms at 25 MHz).
REQ-002 Parameter REPEAT_RATE, default 1250000, cycles between subsequent auto-repeat pulses (50 ms).
REQ-003 Parameters KEY_DOWN / KEY_LEFT / KEY_RIGHT, defaults 8'h32 / 8'h34 / 8'h36, non-extended repeat-key scancodes.
REQ-004 Parameters KEY_ROT / KEY_DROP, defaults 8'h1D / 8'h29, one-shot key scancodes.
REQ-005 clk  input  1  system clock, 25 MHz; single clock domain.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 fifo_empty  input  1  high when the ps2_if receive FIFO holds no byte.
REQ-008 fifo_data  input  8  FIFO head byte, first-word-fall-through, valid while fifo_empty is low.
REQ-009 fifo_rd  output  1  one-cycle pop strobe to ps2_if.
REQ-010 key_valid  output  1  one-cycle strobe per completed make/break event.
REQ-011 key_code  output  8  final scancode byte of the event; held until the next event.
REQ-012 key_ext  output  1  event was E0-prefixed.
REQ-013 key_break  output  1  event was a release (F0-prefixed).
REQ-014 held  output  5  live key state {drop, rot, right, left, down}.
REQ-015 down_pulse, left_pulse, right_pulse, rot_pulse, drop_pulse  output  1 each  one-cycle game-command pulses.

Function
REQ-016 Pop: fifo_rd asserts only when fifo_empty is low and fifo_rd was low the previous cycle (at most one pop every two cycles); fifo_data is consumed in the cycle fifo_rd is high.
REQ-017 Prefix FSM states: IDLE, EXT, BRK, EXT_BRK; each consumed byte causes exactly one transition.
REQ-018 IDLE: E0->EXT; F0->BRK; AA, FA, EE, FE, 00, FF, E1->IDLE with no event; other byte->make event (ext=0), IDLE.
REQ-019 EXT: F0->EXT_BRK; E0->EXT; other byte->make event (ext=1), IDLE.
REQ-020 BRK: any byte other than E0/F0->break event (ext=0), IDLE; E0 or F0 here->discard, IDLE.
REQ-021 EXT_BRK: byte->break event (ext=1), IDLE; E0 or F0 here->discard, IDLE.
REQ-022 Event latency: key_valid, key_code, key_ext, key_break update in the cycle after the final byte's fifo_rd.
REQ-023 Key match requires ext=0 and key_code equal to the KEY_* parameter; held bit sets on make and clears on break in the same cycle as key_valid.
REQ-024 One-shot keys: rot_pulse/drop_pulse fire with key_valid on a make only when the held bit was previously clear; keyboard typematic repeats fire nothing.
REQ-025 Repeat keys: on a make with held bit clear, the pulse fires with key_valid and the key's timer loads REPEAT_DELAY-1.
REQ-026 Repeat timer counts down while the key is held; at zero the pulse fires and the timer reloads REPEAT_RATE-1.
REQ-027 Typematic makes of an already-held repeat key neither fire a pulse nor reload the timer.
REQ-028 Break clears the timer; a break coinciding with expiry suppresses that pulse.
REQ-029 Each repeat key has its own timer; simultaneous expiries produce simultaneous pulses.
REQ-030 Timers are 24 bits wide; parameters exceeding 2^24 are illegal.

Reset
REQ-031 rst asserted: FSM->IDLE; fifo_rd, key_valid, key_ext, key_break, all pulses=0; key_code=8'h00; held=0; all timers cleared.
REQ-032 Reset mid-sequence discards any partial prefix; the next byte after release is decoded from IDLE.

Structure
REQ-033 Shared header ps2_key_defs.vh holds FSM state encodings, special bytes (E0, F0, E1, AA, FA, EE, FE) and default key codes.
REQ-034 Sub-module key_repeat (held in, make/break strobes in, pulse out, 24-bit timer) is instantiated three times.

Verification
REQ-035 Bytes 34 -> make event: key_code=34, ext=0, break=0; left_pulse once; held[1]=1.
REQ-036 Bytes E0 F0 75 -> one break event: ext=1, code=75; no game pulse; no held change.
REQ-037 With REPEAT_DELAY=10 and REPEAT_RATE=4, hold 32 for 30 cycles -> down_pulse at make and at +10, +14, +18, +22, +26; stops at break F0 32.
REQ-038 Bytes 1D 1D 1D F0 1D -> exactly one rot_pulse; held[3] clears with the break event.
REQ-039 Bytes AA FA -> no events; continuous non-empty FIFO -> fifo_rd never high two consecutive cycles.
REQ-040 rst pulse after E0 F0, then byte 36 -> make event with ext=0; right_pulse fires.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: prefix FSM states, special
// scancode bytes, default game-key codes and the repeat timer width.
package ps2_key_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BYTE_EXT    = 8'hE0;
    localparam logic [7:0] BYTE_BRK    = 8'hF0;
    localparam logic [7:0] BYTE_PAUSE  = 8'hE1;
    localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_ECHO   = 8'hEE;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [7:0] BYTE_ERR0   = 8'h00;
    localparam logic [7:0] BYTE_ERR1   = 8'hFF;

    localparam logic [7:0] DEF_KEY_DOWN  = 8'h32;
    localparam logic [7:0] DEF_KEY_LEFT  = 8'h34;
    localparam logic [7:0] DEF_KEY_RIGHT = 8'h36;
    localparam logic [7:0] DEF_KEY_ROT   = 8'h1D;
    localparam logic [7:0] DEF_KEY_DROP  = 8'h29;

    localparam int TIMER_W = 24;

    // Keyboard status/response bytes that never start a key event.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == BYTE_BAT_OK) || (b == BYTE_ACK) || (b == BYTE_ECHO) ||
               (b == BYTE_RESEND) || (b == BYTE_ERR0) || (b == BYTE_ERR1) ||
               (b == BYTE_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_key_repeat.sv
// Auto-repeat generator for one game key: pulse on fresh make, then after
// REPEAT_DELAY cycles and every REPEAT_RATE cycles while the key stays held.
module ps2_key_decoder_key_repeat
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 6250000,
    parameter int unsigned REPEAT_RATE  = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic held,
    input  logic make,
    input  logic brk,
    output logic pulse
);

    localparam logic [TIMER_W-1:0] DELAY_LD = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] RATE_LD  = TIMER_W'(REPEAT_RATE - 1);

    logic [TIMER_W-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (brk) begin
                // A release wins over an expiry landing in the same cycle.
                timer <= '0;
            end else if (make && !held) begin
                timer <= DELAY_LD;
                pulse <= 1'b1;
            end else if (held) begin
                if (timer == '0) begin
                    timer <= RATE_LD;
                    pulse <= 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops scancode bytes from the PS/2 receive FIFO, strips E0/F0 prefixes into
// make/break events and turns the game keys into held state and command pulses.
//
//   state      | meaning
//   ST_IDLE    | waiting for the first byte of an event
//   ST_EXT     | E0 seen, next non-prefix byte is an extended make
//   ST_BRK     | F0 seen, next byte is a break
//   ST_EXT_BRK | E0 F0 seen, next byte is an extended break
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 6250000,
    parameter int unsigned REPEAT_RATE  = 1250000,
    parameter logic [7:0]  KEY_DOWN     = DEF_KEY_DOWN,
    parameter logic [7:0]  KEY_LEFT     = DEF_KEY_LEFT,
    parameter logic [7:0]  KEY_RIGHT    = DEF_KEY_RIGHT,
    parameter logic [7:0]  KEY_ROT      = DEF_KEY_ROT,
    parameter logic [7:0]  KEY_DROP     = DEF_KEY_DROP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [4:0] held,
    output logic       down_pulse,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic       rot_pulse,
    output logic       drop_pulse
);

    ps2_state_e state, state_nx;
    logic       consume;
    logic       evt, evt_ext, evt_brk;
    logic [4:0] key_hit, key_make, key_brk;

    assign consume = fifo_rd && !fifo_empty;

    always_comb begin
        state_nx = state;
        evt      = 1'b0;
        evt_ext  = 1'b0;
        evt_brk  = 1'b0;
        if (consume) begin
            case (state)
                ST_IDLE: begin
                    if (fifo_data == BYTE_EXT)      state_nx = ST_EXT;
                    else if (fifo_data == BYTE_BRK) state_nx = ST_BRK;
                    else if (!is_ctrl_byte(fifo_data)) evt = 1'b1;
                end
                ST_EXT: begin
                    if (fifo_data == BYTE_BRK)      state_nx = ST_EXT_BRK;
                    else if (fifo_data != BYTE_EXT) begin
                        evt      = 1'b1;
                        evt_ext  = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_nx = ST_IDLE;
                    if (fifo_data != BYTE_EXT && fifo_data != BYTE_BRK) begin
                        evt     = 1'b1;
                        evt_brk = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    if (fifo_data != BYTE_EXT && fifo_data != BYTE_BRK) begin
                        evt     = 1'b1;
                        evt_ext = 1'b1;
                        evt_brk = 1'b1;
                    end
                end
            endcase
        end
    end

    // Game keys are only ever the non-extended codes.
    assign key_hit  = {fifo_data == KEY_DROP, fifo_data == KEY_ROT,
                       fifo_data == KEY_RIGHT, fifo_data == KEY_LEFT,
                       fifo_data == KEY_DOWN};
    assign key_make = (evt && !evt_ext && !evt_brk) ? key_hit : 5'b0;
    assign key_brk  = (evt && !evt_ext &&  evt_brk) ? key_hit : 5'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fifo_rd    <= 1'b0;
            key_valid  <= 1'b0;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            held       <= 5'b0;
            rot_pulse  <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            fifo_rd    <= !fifo_empty && !fifo_rd;
            key_valid  <= evt;
            if (evt) begin
                key_code  <= fifo_data;
                key_ext   <= evt_ext;
                key_break <= evt_brk;
            end
            held       <= (held | key_make) & ~key_brk;
            rot_pulse  <= key_make[3] && !held[3];
            drop_pulse <= key_make[4] && !held[4];
        end
    end

    ps2_key_decoder_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_down (
        .clk(clk), .rst(rst), .held(held[0]), .make(key_make[0]), .brk(key_brk[0]), .pulse(down_pulse)
    );

    ps2_key_decoder_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_left (
        .clk(clk), .rst(rst), .held(held[1]), .make(key_make[1]), .brk(key_brk[1]), .pulse(left_pulse)
    );

    ps2_key_decoder_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_right (
        .clk(clk), .rst(rst), .held(held[2]), .make(key_make[2]), .brk(key_brk[2]), .pulse(right_pulse)
    );

endmodule
